// File: rtl/recirc_pkg.sv
// recirc_pkg: shared constants and types for the recirculation return merger.
package recirc_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int LANES              = 4;
    localparam int STAT_W             = 16;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        WAIT   = 2'd1,
        IDLE   = 2'd2
    } idle_state_e;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == {STAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/recirc_lane_fifo.sv
// recirc_lane_fifo: per-lane return FIFO with sticky overflow flag.
// A push to a full FIFO is accepted only when a pop frees a slot in the same cycle.
module recirc_lane_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  pop_ok_s, push_ok_s, full_s;

    assign empty    = (count_q == {(PW+1){1'b0}});
    assign full_s   = (count_q == (PW+1)'(DEPTH));
    assign dout     = mem_q[rd_ptr_q];
    assign overflow = overflow_q;

    // Next-state: pointer/count update, write, and overflow capture.
    always_comb begin
        mem_d      = mem_q;
        pop_ok_s   = pop && !empty;
        push_ok_s  = push && (!full_s || pop_ok_s);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            overflow_d = overflow_q | push;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + {{PW{1'b0}}, 1'b1};
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - {{PW{1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State registers; reset empties the FIFO and clears the overflow flag.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {(PW+1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/recirc_return_merger.sv
// recirc_return_merger: merges returned and fresh lanes onto the registered
// recirculator inputs (returned traffic first) and generates selector_IDLE.
// Optional macro RECIRC_STATS_EN adds per-lane retCount/newCount counters.
module recirc_return_merger
    import recirc_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [4*DATA_WIDTH-1:0] retData,
    input  logic [3:0]              retValid,
    input  logic [4*DATA_WIDTH-1:0] newData,
    input  logic [3:0]              newValid,
    output logic [3:0]              newReady,
    output logic [4*DATA_WIDTH-1:0] dataOut,
    output logic [3:0]              validOut,
    output logic                    selector_IDLE,
    output logic [3:0]              overflow
`ifdef RECIRC_STATS_EN
    ,
    output logic [4*STAT_W-1:0]     retCount,
    output logic [4*STAT_W-1:0]     newCount
`endif
);
    localparam int CW = $clog2(IDLE_CYCLES) + 1;

    logic [DATA_WIDTH-1:0]   fifo_dout_s [LANES];
    logic [LANES-1:0]        fifo_empty_s;
    logic [LANES-1:0]        fifo_push_s;
    logic [LANES-1:0]        fifo_pop_s;
    logic [4*DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]              valid_q, valid_d;
    idle_state_e             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    idle_q, idle_d;
    logic                    quiet_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        recirc_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset_L  (reset_L),
            .push     (fifo_push_s[g]),
            .pop      (fifo_pop_s[g]),
            .din      (retData[g*DATA_WIDTH +: DATA_WIDTH]),
            .dout     (fifo_dout_s[g]),
            .empty    (fifo_empty_s[g]),
            .overflow (overflow[g])
        );
    end

    assign newReady      = fifo_empty_s & ~retValid;
    assign quiet_s       = (&fifo_empty_s) && (retValid == 4'b0000) && (newValid == 4'b0000);
    assign dataOut       = data_q;
    assign validOut      = valid_q;
    assign selector_IDLE = idle_q;

    // Per-lane arbitration: FIFO backlog, then returned bypass, then fresh word.
    always_comb begin
        data_d      = data_q;
        valid_d     = 4'b0000;
        fifo_push_s = 4'b0000;
        fifo_pop_s  = 4'b0000;
        for (int i = 0; i < LANES; i++) begin
            if (!fifo_empty_s[i]) begin
                data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout_s[i];
                valid_d[i]     = 1'b1;
                fifo_pop_s[i]  = 1'b1;
                fifo_push_s[i] = retValid[i];
            end else if (retValid[i]) begin
                data_d[i*DATA_WIDTH +: DATA_WIDTH] = retData[i*DATA_WIDTH +: DATA_WIDTH];
                valid_d[i] = 1'b1;
            end else if (newValid[i]) begin
                data_d[i*DATA_WIDTH +: DATA_WIDTH] = newData[i*DATA_WIDTH +: DATA_WIDTH];
                valid_d[i] = 1'b1;
            end else begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Idle FSM next state: count quiet cycles, drop out on any activity.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = 1'b0;
        case (state_q)
            ACTIVE: begin
                cnt_d = {CW{1'b0}};
                if (quiet_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = ACTIVE;
                end
            end
            WAIT: begin
                if (!quiet_s) begin
                    state_d = ACTIVE;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q >= CW'(IDLE_CYCLES - 1)) begin
                    state_d = IDLE;
                    idle_d  = 1'b1;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            IDLE: begin
                if (!quiet_s) begin
                    state_d = ACTIVE;
                    cnt_d   = {CW{1'b0}};
                    idle_d  = 1'b0;
                end else begin
                    idle_d  = 1'b1;
                end
            end
            default: begin
                state_d = ACTIVE;
                cnt_d   = {CW{1'b0}};
                idle_d  = 1'b0;
            end
        endcase
    end

    // Output lane registers and idle FSM registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= {(4*DATA_WIDTH){1'b0}};
            valid_q <= 4'b0000;
            state_q <= ACTIVE;
            cnt_q   <= {CW{1'b0}};
            idle_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
        end
    end

`ifdef RECIRC_STATS_EN
    logic [4*STAT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [4*STAT_W-1:0] new_cnt_q, new_cnt_d;

    assign retCount = ret_cnt_q;
    assign newCount = new_cnt_q;

    // Statistics: count forwarded returned and fresh words per lane.
    always_comb begin
        ret_cnt_d = ret_cnt_q;
        new_cnt_d = new_cnt_q;
        for (int i = 0; i < LANES; i++) begin
            if (!fifo_empty_s[i] || retValid[i]) begin
                ret_cnt_d[i*STAT_W +: STAT_W] = sat_inc(ret_cnt_q[i*STAT_W +: STAT_W]);
            end else if (newValid[i]) begin
                new_cnt_d[i*STAT_W +: STAT_W] = sat_inc(new_cnt_q[i*STAT_W +: STAT_W]);
            end else begin
                ret_cnt_d[i*STAT_W +: STAT_W] = ret_cnt_q[i*STAT_W +: STAT_W];
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ret_cnt_q <= {(4*STAT_W){1'b0}};
            new_cnt_q <= {(4*STAT_W){1'b0}};
        end else begin
            ret_cnt_q <= ret_cnt_d;
            new_cnt_q <= new_cnt_d;
        end
    end
`endif

endmodule

// File: doc/recirc_return_merger.md
Name: recirc_return_merger

Overview:
Return path for the recirculation loop. Four returned lanes (recirculated words) and four fresh source lanes enter this block. Per lane, it merges them onto the four registered lanes that feed the recirculator inputs, and returned traffic always has priority. It also generates selector_IDLE for the recirculator once the loop has been quiet for a programmable number of cycles.

Parameters:
DATA_WIDTH, 8, width of each lane word
FIFO_DEPTH, 4, per-lane return FIFO entries (power of 2, minimum 2)
IDLE_CYCLES, 8, consecutive quiet cycles before selector_IDLE is asserted (minimum 1)

Ports:
clk  in  1  single clock, all logic on rising edge
reset_L  in  1  asynchronous, active-low reset
retData  in  4*DATA_WIDTH  returned words, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
retValid  in  4  returned word valid per lane (no backpressure to this side)
newData  in  4*DATA_WIDTH  fresh source words
newValid  in  4  fresh word valid per lane
newReady  out  4  fresh word accepted this cycle (combinational)
dataOut  out  4*DATA_WIDTH  registered merged words, drives recirculator dataIn0..3
validOut  out  4  registered valid per lane, drives validIn0..3
selector_IDLE  out  1  registered idle indication to recirculator
overflow  out  4  sticky per-lane return-FIFO overflow flag

Behaviour:
- Reset (reset_L=0, asynchronous): dataOut=0, validOut=0, selector_IDLE=0, overflow=0, FIFOs empty, idle counter=0, FSM=ACTIVE. Effect is immediate. Mid-operation reset discards FIFO contents.
- Per lane i, each cycle, priority (evaluated on this cycle's inputs, registered at the edge):
  1) FIFO non-empty: pop head to dataOut, validOut=1. A simultaneous retValid pushes to the tail.
  2) FIFO empty and retValid: bypass retData to dataOut, validOut=1. Nothing is written to the FIFO.
  3) FIFO empty, no retValid, newValid: newData goes to dataOut, validOut=1.
  4) Otherwise validOut=0 and dataOut holds its previous value.
- newReady[i] = FIFO empty AND !retValid[i]. A fresh word is consumed only when newValid && newReady.
- Latency: one cycle from input to dataOut. A returned word waits at most FIFO_DEPTH extra cycles.
- Full FIFO with retValid: a simultaneous pop frees a slot, so the push succeeds. A FIFO can only be full and receive a push without a pop if it is already full at the start of the cycle with a pop pending, which cannot happen. Any push to a full FIFO with no pop is dropped and sets overflow[i] sticky until reset.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The count is log2(FIFO_DEPTH)+1 bits.
- quiet = all FIFOs empty AND retValid==0 AND newValid==0.
- Idle FSM (registered):
  - ACTIVE: counter=0; if quiet -> WAIT.
  - WAIT: if !quiet -> ACTIVE, counter=0. Else counter++. When counter reaches IDLE_CYCLES-1 -> IDLE.
  - IDLE: selector_IDLE=1. Any !quiet -> ACTIVE and selector_IDLE=0 on the same edge.
- The counter saturates and never wraps.

Optional Feature:
RECIRC_STATS_EN
- Defined: adds output ports retCount (4*16) and newCount (4*16). These are per-lane 16-bit saturating counts of returned words and fresh words forwarded to dataOut. They reset to 0 and saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package recirc_pkg: DATA_WIDTH default, LANES=4, the idle FSM state encoding (ACTIVE=2'd0, WAIT=2'd1, IDLE=2'd2), and the stats counter width 16.
- Sub-module recirc_lane_fifo (one per lane, generate loop): push, pop, data, empty, full, overflow. The top module holds the arbitration, the output registers and the idle FSM.

Test Plan:
- Reset: hold reset_L=0 with random inputs -> all outputs 0; release, no stimulus -> selector_IDLE=1 exactly IDLE_CYCLES+1 edges after release.
- Bypass: lane0 retValid=1, retData=8'hA5, FIFO empty -> next edge dataOut[7:0]=A5, validOut[0]=1, newReady[0]=0 in that cycle.
- Priority and backpressure: lane2 newValid=1, newData=8'h11 held; ret words 8'h01,02,03 on consecutive cycles while lane2 FIFO is pre-filled with 8'hF0 -> output order F0,01,02,03 then 11; newReady[2]=1 only in the cycle 11 is accepted.
- FIFO full and wrap: 8 consecutive returned words 8'h10..8'h17 on lane3 with a 2-deep backlog -> in-order output, no drops, overflow[3]=0; pointers wrap twice.
- Idle exit: selector_IDLE=1, then newValid[1]=1 -> selector_IDLE=0 on the next edge and the word is forwarded the same edge.
- Stats (RECIRC_STATS_EN): 5 returned and 3 fresh words on lane1 -> retCount lane1=5, newCount lane1=3; force 65540 returns -> retCount=16'hFFFF.
